// File: rtl/butterfly_unit.sv
// Radix-2 complex butterfly: y0 = A + B*W, y1 = A - B*W with W from an internal twiddle ROM.
// One operation in flight; the FSM walks IDLE -> FETCH (two-cycle ROM read) -> MULT -> SUM -> OUT.
module butterfly_unit #(
    parameter int DATA_W = 8,
    parameter int TW_AW  = 3,
    parameter int FRAC_W = DATA_W - 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic        [TW_AW-1:0]  tw_idx,
    input  logic                     inverse,
    input  logic                     scale,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] y0_re,
    output logic signed [DATA_W-1:0] y0_im,
    output logic signed [DATA_W-1:0] y1_re,
    output logic signed [DATA_W-1:0] y1_im,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int TW_N = 2 ** TW_AW;
    localparam int PW   = 2 * DATA_W;
    localparam int RW   = 2 * DATA_W + 2;
    localparam int SW   = DATA_W + 2;
    localparam logic signed [RW-1:0] RND     = RW'(2 ** (FRAC_W - 1));
    localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2 ** (DATA_W - 1)));

    // Elaboration-time twiddle value; Taylor series keeps the table free of $cos/$sin.
    function automatic int tw_val(input int k, input bit want_sin);
        real th, term, acc, scaled;
        int  v;
        th = 2.0 * 3.14159265358979323846 * real'(k) / real'(2 ** (TW_AW + 1));
        term = want_sin ? th : 1.0;
        acc  = term;
        for (int n = 1; n < 24; n++) begin
            if (want_sin) term = -term * th * th / real'((2 * n) * (2 * n + 1));
            else          term = -term * th * th / real'((2 * n - 1) * (2 * n));
            acc = acc + term;
        end
        scaled = acc * (2.0 ** FRAC_W);
        if (scaled >= 0.0) v = $rtoi(scaled + 0.5);
        else               v = -$rtoi(0.5 - scaled);
        if (v > 2 ** (DATA_W - 1) - 1) v = 2 ** (DATA_W - 1) - 1;
        if (v < -(2 ** (DATA_W - 1)))  v = -(2 ** (DATA_W - 1));
        return v;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SAT_MAX) return DATA_W'(SAT_MAX);
        if (x < SAT_MIN) return DATA_W'(SAT_MIN);
        return DATA_W'(x);
    endfunction

    logic signed [DATA_W-1:0] cos_tab [TW_N];
    logic signed [DATA_W-1:0] sin_tab [TW_N];
    for (genvar gi = 0; gi < TW_N; gi++) begin : g_rom
        localparam int C_V = tw_val(gi, 1'b0);
        localparam int S_V = tw_val(gi, 1'b1);
        assign cos_tab[gi] = DATA_W'(C_V);
        assign sin_tab[gi] = DATA_W'(S_V);
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MULT, S_SUM, S_OUT} state_t;
    state_t state_q, state_d;

    logic signed [DATA_W-1:0] a_re_q, a_re_d, a_im_q, a_im_d, b_re_q, b_re_d, b_im_q, b_im_d;
    logic        [TW_AW-1:0]  k_q, k_d;
    logic                     inv_q, inv_d, scale_q, scale_d, rom_vld_q, rom_vld_d;
    logic signed [DATA_W-1:0] rom_c_q, rom_c_d, rom_s_q, rom_s_d, w_re_q, w_re_d, w_im_q, w_im_d;
    logic signed [PW-1:0]     p_rr_q, p_rr_d, p_ii_q, p_ii_d, p_ri_q, p_ri_d, p_ir_q, p_ir_d;
    logic signed [DATA_W-1:0] y0_re_q, y0_re_d, y0_im_q, y0_im_d, y1_re_q, y1_re_d, y1_im_q, y1_im_d;
    logic signed [RW-1:0]     t_re_w, t_im_w;
    logic signed [SW-1:0]     t_re_r, t_im_r, s0_re, s0_im, s1_re, s1_im;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_FETCH;
            S_FETCH: if (rom_vld_q) state_d = S_MULT;
            S_MULT:  state_d = S_SUM;
            S_SUM:   state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_OUT);
        y0_re     = y0_re_q;
        y0_im     = y0_im_q;
        y1_re     = y1_re_q;
        y1_im     = y1_im_q;
    end

    // Rounded twiddle product and the two sums, widened so nothing wraps before saturation.
    always_comb begin
        t_re_w = RW'(p_rr_q) - RW'(p_ii_q) + RND;
        t_im_w = RW'(p_ri_q) + RW'(p_ir_q) + RND;
        t_re_r = SW'(t_re_w >>> FRAC_W);
        t_im_r = SW'(t_im_w >>> FRAC_W);
        s0_re  = SW'(a_re_q) + t_re_r;
        s0_im  = SW'(a_im_q) + t_im_r;
        s1_re  = SW'(a_re_q) - t_re_r;
        s1_im  = SW'(a_im_q) - t_im_r;
        if (scale_q) begin
            s0_re = (s0_re + SW'(1)) >>> 1;
            s0_im = (s0_im + SW'(1)) >>> 1;
            s1_re = (s1_re + SW'(1)) >>> 1;
            s1_im = (s1_im + SW'(1)) >>> 1;
        end
    end

    always_comb begin
        a_re_d = a_re_q;  a_im_d = a_im_q;  b_re_d = b_re_q;  b_im_d = b_im_q;
        k_d = k_q;  inv_d = inv_q;  scale_d = scale_q;  rom_vld_d = rom_vld_q;
        rom_c_d = rom_c_q;  rom_s_d = rom_s_q;  w_re_d = w_re_q;  w_im_d = w_im_q;
        p_rr_d = p_rr_q;  p_ii_d = p_ii_q;  p_ri_d = p_ri_q;  p_ir_d = p_ir_q;
        y0_re_d = y0_re_q;  y0_im_d = y0_im_q;  y1_re_d = y1_re_q;  y1_im_d = y1_im_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                a_re_d = a_re;  a_im_d = a_im;  b_re_d = b_re;  b_im_d = b_im;
                k_d = tw_idx;  inv_d = inverse;  scale_d = scale;  rom_vld_d = 1'b0;
            end
            S_FETCH: begin
                // First cycle reads the ROM, second cycle takes its registered output.
                rom_c_d   = cos_tab[k_q];
                rom_s_d   = sin_tab[k_q];
                rom_vld_d = 1'b1;
                if (rom_vld_q) begin
                    w_re_d = rom_c_q;
                    w_im_d = inv_q ? rom_s_q : -rom_s_q;
                end
            end
            S_MULT: begin
                p_rr_d = PW'(b_re_q) * PW'(w_re_q);
                p_ii_d = PW'(b_im_q) * PW'(w_im_q);
                p_ri_d = PW'(b_re_q) * PW'(w_im_q);
                p_ir_d = PW'(b_im_q) * PW'(w_re_q);
            end
            S_SUM: begin
                y0_re_d = sat(s0_re);  y0_im_d = sat(s0_im);
                y1_re_d = sat(s1_re);  y1_im_d = sat(s1_im);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_re_q <= '0;  a_im_q <= '0;  b_re_q <= '0;  b_im_q <= '0;
            k_q <= '0;  inv_q <= 1'b0;  scale_q <= 1'b0;  rom_vld_q <= 1'b0;
            rom_c_q <= '0;  rom_s_q <= '0;  w_re_q <= '0;  w_im_q <= '0;
            p_rr_q <= '0;  p_ii_q <= '0;  p_ri_q <= '0;  p_ir_q <= '0;
            y0_re_q <= '0;  y0_im_q <= '0;  y1_re_q <= '0;  y1_im_q <= '0;
        end else begin
            a_re_q <= a_re_d;  a_im_q <= a_im_d;  b_re_q <= b_re_d;  b_im_q <= b_im_d;
            k_q <= k_d;  inv_q <= inv_d;  scale_q <= scale_d;  rom_vld_q <= rom_vld_d;
            rom_c_q <= rom_c_d;  rom_s_q <= rom_s_d;  w_re_q <= w_re_d;  w_im_q <= w_im_d;
            p_rr_q <= p_rr_d;  p_ii_q <= p_ii_d;  p_ri_q <= p_ri_d;  p_ir_q <= p_ir_d;
            y0_re_q <= y0_re_d;  y0_im_q <= y0_im_d;  y1_re_q <= y1_re_d;  y1_im_q <= y1_im_d;
        end
    end
endmodule

// File: tb/tb_butterfly_unit.sv
// Bench for butterfly_unit: directed vector table, random vectors against a real-arithmetic
// reference model, and hand sequences for backpressure, re-acceptance and mid-flight reset.
module tb_butterfly_unit;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int FW = DW - 1;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int k, a_re, a_im, b_re, b_im, inv, scl;
        int e0r, e0i, e1r, e1i;
    } vec_t;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b0;
    logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic        [AW-1:0] tw_idx = '0;
    logic                 inverse = 1'b0, scale = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic                 in_ready, out_valid;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

    int tests_run = 0;
    int tests_failed = 0;

    butterfly_unit #(.DATA_W(DW), .TW_AW(AW), .FRAC_W(FW)) dut (
        .Clock(Clock), .Reset(Reset),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .tw_idx(tw_idx), .inverse(inverse), .scale(scale),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 Clock = ~Clock;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    function automatic int fdiv(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int clamp(input int x, input int lo, input int hi);
        return (x < lo) ? lo : (x > hi) ? hi : x;
    endfunction

    // Reference: twiddle from $cos/$sin, integer products, floor-rounded shifts, saturation.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        real  th;
        int   c, s, wr, wi, tr, ti, q[4];
        int   one = 1 << FW;
        int   hi = (1 << (DW - 1)) - 1;
        int   lo = -(1 << (DW - 1));
        r  = v;
        th = 2.0 * PI * real'(v.k) / real'(1 << (AW + 1));
        c  = clamp(rnd($cos(th) * real'(one)), lo, hi);
        s  = clamp(rnd($sin(th) * real'(one)), lo, hi);
        wr = c;
        wi = v.inv ? s : -s;
        tr = fdiv(v.b_re * wr - v.b_im * wi + one / 2, one);
        ti = fdiv(v.b_re * wi + v.b_im * wr + one / 2, one);
        q[0] = v.a_re + tr;  q[1] = v.a_im + ti;
        q[2] = v.a_re - tr;  q[3] = v.a_im - ti;
        for (int i = 0; i < 4; i++) begin
            if (v.scl != 0) q[i] = fdiv(q[i] + 1, 2);
            q[i] = clamp(q[i], lo, hi);
        end
        r.e0r = q[0];  r.e0i = q[1];  r.e1r = q[2];  r.e1i = q[3];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.k    = int'($urandom_range(0, (1 << AW) - 1));
        v.a_re = int'($urandom_range(0, 255)) - 128;
        v.a_im = int'($urandom_range(0, 255)) - 128;
        v.b_re = int'($urandom_range(0, 255)) - 128;
        v.b_im = int'($urandom_range(0, 255)) - 128;
        v.inv  = int'($urandom_range(0, 1));
        v.scl  = int'($urandom_range(0, 1));
        return model(v);
    endfunction

    task automatic drive(input vec_t v);
        tw_idx  = AW'(v.k);
        a_re    = DW'(v.a_re);
        a_im    = DW'(v.a_im);
        b_re    = DW'(v.b_re);
        b_im    = DW'(v.b_im);
        inverse = v.inv[0];
        scale   = v.scl[0];
    endtask

    task automatic scramble();
        vec_t j;
        j = rand_vec();
        drive(j);
    endtask

    // Presents v for one edge while in IDLE, then changes every input to junk.
    task automatic start(input string name, input vec_t v);
        check({name, "_in_ready"}, int'(in_ready), 1);
        drive(v);
        in_valid = 1'b1;
        @(posedge Clock); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_out(input string name);
        int lat = -1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clock); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({name, "_latency"}, lat, 4);
    endtask

    task automatic check_y(input string name, input vec_t v);
        check({name, "_y0_re"}, int'(y0_re), v.e0r);
        check({name, "_y0_im"}, int'(y0_im), v.e0i);
        check({name, "_y1_re"}, int'(y1_re), v.e1r);
        check({name, "_y1_im"}, int'(y1_im), v.e1i);
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge Clock); #1;
        out_ready = 1'b0;
        check({name, "_out_valid_clr"}, int'(out_valid), 0);
        check({name, "_in_ready_idle"}, int'(in_ready), 1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        start(name, v);
        wait_out(name);
        check_y(name, v);
        release_out(name);
    endtask

    initial begin
        vec_t dir_tab[7];
        vec_t v, w;

        //                k  are aim bre bim inv scl  e0r  e0i  e1r  e1i
        dir_tab[0] = '{0,   10,   0,  20,   0, 0, 0,   30,   0, -10,   0};
        dir_tab[1] = '{4,    0,   0,  20,   0, 0, 0,    0, -20,   0,  20};
        dir_tab[2] = '{4,    0,   0,  20,   0, 1, 0,    0,  20,   0, -20};
        dir_tab[3] = '{0,  127,   0, 127,   0, 0, 0,  127,   0,   1,   0};
        dir_tab[4] = '{0,  127,   0, 127,   0, 0, 1,  127,   0,   1,   0};
        dir_tab[5] = '{2,    0,   0, 100,   0, 0, 0,   71, -71, -71,  71};
        dir_tab[6] = '{0, -128,-128,-128,-128, 0, 0, -128,-128,  -1,  -1};

        #2 Reset = 1'b1;
        #3;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_y0_re", int'(y0_re), 0);
        check("reset_y1_im", int'(y1_im), 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;

        for (int i = 0; i < 7; i++) run_vec($sformatf("dir%0d", i), dir_tab[i]);

        for (int i = 0; i < 40; i++) begin
            v = rand_vec();
            run_vec($sformatf("rnd%0d", i), v);
        end

        // Backpressure: outputs hold, in_valid ignored, and no accept on the leaving edge.
        v = rand_vec();
        w = rand_vec();
        start("bp", v);
        wait_out("bp");
        check_y("bp", v);
        for (int i = 0; i < 5; i++) begin
            drive(w);
            in_valid = 1'b1;
            @(posedge Clock); #1;
            check($sformatf("bp_hold%0d_out_valid", i), int'(out_valid), 1);
            check($sformatf("bp_hold%0d_in_ready", i), int'(in_ready), 0);
            check_y($sformatf("bp_hold%0d", i), v);
        end
        out_ready = 1'b1;
        @(posedge Clock); #1;
        out_ready = 1'b0;
        check("bp_leave_out_valid", int'(out_valid), 0);
        check("bp_leave_in_ready", int'(in_ready), 1);
        @(posedge Clock); #1;
        check("bp_reaccept_in_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        scramble();
        wait_out("bp_second");
        check_y("bp_second", w);
        release_out("bp_second");

        // Reset while the butterfly sits in MULT (two edges after the FETCH entry).
        v = rand_vec();
        start("rst", v);
        @(posedge Clock);
        @(posedge Clock); #1;
        Reset = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_y0_re", int'(y0_re), 0);
        check("rst_y0_im", int'(y0_im), 0);
        check("rst_y1_re", int'(y1_re), 0);
        check("rst_y1_im", int'(y1_im), 0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        w = rand_vec();
        run_vec("rst_after", w);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
